// File: rtl/write_pulse_gen_if.sv
// Write-port bundle between board I/O and the register-file front end.
// The slave side is the pulse generator; the master side is the board (or bench).
interface write_pulse_gen_if #(
  parameter int unsigned ADR_W  = 3,
  parameter int unsigned DATA_W = 4
);
  logic              btn_raw;
  logic [ADR_W-1:0]  sw_adr;
  logic [DATA_W-1:0] sw_din;
  logic              auto_inc;
  logic [ADR_W-1:0]  W_Adr;
  logic [DATA_W-1:0] Din;
  logic              we_pulse;
  logic              busy;

  modport master (
    output btn_raw,
    output sw_adr,
    output sw_din,
    output auto_inc,
    input  W_Adr,
    input  Din,
    input  we_pulse,
    input  busy
  );

  modport slave (
    input  btn_raw,
    input  sw_adr,
    input  sw_din,
    input  auto_inc,
    output W_Adr,
    output Din,
    output we_pulse,
    output busy
  );
endinterface

// File: rtl/write_pulse_gen.sv
// Button-driven write strobe generator: synchronise, debounce, edge-detect, and
// capture address/data for a single-cycle register-file write.
module write_pulse_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned ADR_W           = 3,
  parameter int unsigned DATA_W          = 4
) (
  input logic                clk,
  input logic                reset,
  write_pulse_gen_if.slave   bus
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StPulse, StHold} state_e;

  state_e            state_q, state_d;
  logic [1:0]        sync_q;
  logic              btn_sync;
  logic              btn_clean_q, btn_clean_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADR_W-1:0]  adr_cnt_q, adr_cnt_d;
  logic [ADR_W-1:0]  w_adr_q, w_adr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              we_q, we_d;

  assign btn_sync = sync_q[1];

  always_comb begin
    state_d     = state_q;
    btn_clean_d = btn_clean_q;
    cnt_d       = cnt_q;
    adr_cnt_d   = adr_cnt_q;
    w_adr_d     = w_adr_q;
    din_d       = din_q;
    we_d        = 1'b0;

    // A new level is accepted only after it has been seen for DEBOUNCE_CYCLES edges.
    if (btn_sync == btn_clean_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      btn_clean_d = btn_sync;
      cnt_d       = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (btn_clean_q) begin
          state_d = StPulse;
          we_d    = 1'b1;
          din_d   = bus.sw_din;
          if (bus.auto_inc) begin
            w_adr_d   = adr_cnt_q;
            adr_cnt_d = adr_cnt_q + ADR_W'(1);
          end else begin
            w_adr_d = bus.sw_adr;
          end
        end
      end
      StPulse: state_d = StHold;
      StHold: begin
        if (!btn_clean_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      sync_q      <= '0;
      btn_clean_q <= 1'b0;
      cnt_q       <= '0;
      adr_cnt_q   <= '0;
      w_adr_q     <= '0;
      din_q       <= '0;
      we_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= {sync_q[0], bus.btn_raw};
      btn_clean_q <= btn_clean_d;
      cnt_q       <= cnt_d;
      adr_cnt_q   <= adr_cnt_d;
      w_adr_q     <= w_adr_d;
      din_q       <= din_d;
      we_q        <= we_d;
    end
  end

  assign bus.W_Adr    = w_adr_q;
  assign bus.Din      = din_q;
  assign bus.we_pulse = we_q;
  assign bus.busy     = (state_q == StPulse) || (state_q == StHold);

endmodule

// File: tb/tb_write_pulse_gen.sv
// Directed bench for write_pulse_gen with DEBOUNCE_CYCLES=4 (press-to-pulse at edge 7).
module tb_write_pulse_gen;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  write_pulse_gen_if #(.ADR_W(3), .DATA_W(4)) bus ();

  write_pulse_gen #(
    .DEBOUNCE_CYCLES(4),
    .ADR_W          (3),
    .DATA_W         (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int e = 1; e <= 20; e++) begin
      tick();
      total++;
      if (bus.W_Adr !== 3'd0 || bus.Din !== 4'h0 || bus.we_pulse !== 1'b0 || bus.busy !== 1'b0)
      begin
        bad++;
        $display("FAIL reset_idle cycle=%0d got adr=%0d din=%h we=%b busy=%b exp all 0",
                 e, bus.W_Adr, bus.Din, bus.we_pulse, bus.busy);
      end
    end
  endtask

  task automatic test_manual();
    bus.sw_adr   = 3'd5;
    bus.sw_din   = 4'hA;
    bus.auto_inc = 1'b0;
    bus.btn_raw  = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      tick();
      total++;
      if (bus.we_pulse !== (e == 7)) begin
        bad++;
        $display("FAIL manual_we edge=%0d got=%b exp=%b", e, bus.we_pulse, (e == 7));
      end
      total++;
      if (bus.busy !== (e >= 7)) begin
        bad++;
        $display("FAIL manual_busy edge=%0d got=%b exp=%b", e, bus.busy, (e >= 7));
      end
      if (e == 7) begin
        total++;
        if (bus.W_Adr !== 3'd5 || bus.Din !== 4'hA) begin
          bad++;
          $display("FAIL manual_capture got adr=%0d din=%h exp adr=5 din=a", bus.W_Adr, bus.Din);
        end
      end
    end
    bus.btn_raw = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      total++;
      if (bus.busy !== (e < 7) || bus.we_pulse !== 1'b0) begin
        bad++;
        $display("FAIL manual_release edge=%0d got busy=%b we=%b exp busy=%b we=0",
                 e, bus.busy, bus.we_pulse, (e < 7));
      end
    end
  endtask

  task automatic test_glitch();
    for (int n = 1; n <= 3; n++) begin
      bus.btn_raw = 1'b1;
      for (int e = 0; e < n + 6; e++) begin
        if (e == n) bus.btn_raw = 1'b0;
        tick();
        total++;
        if (bus.we_pulse !== 1'b0 || bus.busy !== 1'b0) begin
          bad++;
          $display("FAIL glitch len=%0d cycle=%0d got we=%b busy=%b exp 0 0",
                   n, e, bus.we_pulse, bus.busy);
        end
      end
    end
  endtask

  task automatic test_auto_inc();
    int pulses;
    pulses = 0;
    bus.auto_inc = 1'b1;
    for (int i = 0; i < 9; i++) begin
      logic [2:0] exp_adr;
      logic [3:0] exp_din;
      exp_adr = 3'(i);
      exp_din = 4'(15 - i);
      bus.sw_din  = exp_din;
      bus.sw_adr  = 3'(7 - i);
      bus.btn_raw = 1'b1;
      for (int e = 1; e <= 10; e++) begin
        tick();
        if (bus.we_pulse === 1'b1) pulses++;
        total++;
        if (bus.we_pulse !== (e == 7)) begin
          bad++;
          $display("FAIL auto_we press=%0d edge=%0d got=%b exp=%b", i, e, bus.we_pulse, (e == 7));
        end
        if (e == 7) begin
          total++;
          if (bus.W_Adr !== exp_adr || bus.Din !== exp_din) begin
            bad++;
            $display("FAIL auto_capture press=%0d got adr=%0d din=%h exp adr=%0d din=%h",
                     i, bus.W_Adr, bus.Din, exp_adr, exp_din);
          end
        end
      end
      bus.btn_raw = 1'b0;
      repeat (8) tick();
      total++;
      if (bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL auto_release press=%0d got busy=%b exp 0", i, bus.busy);
      end
    end
    total++;
    if (pulses != 9) begin
      bad++;
      $display("FAIL auto_count got=%0d exp=9", pulses);
    end
  endtask

  task automatic test_long_hold();
    int pulses;
    pulses = 0;
    bus.auto_inc = 1'b0;
    bus.sw_adr   = 3'd2;
    bus.sw_din   = 4'h3;
    bus.btn_raw  = 1'b1;
    for (int e = 1; e <= 100; e++) begin
      tick();
      if (bus.we_pulse === 1'b1) pulses++;
      if (e == 7) begin
        total++;
        if (bus.W_Adr !== 3'd2 || bus.Din !== 4'h3) begin
          bad++;
          $display("FAIL hold_capture got adr=%0d din=%h exp adr=2 din=3", bus.W_Adr, bus.Din);
        end
      end
      if (e == 50) begin
        bus.sw_din   = 4'hC;
        bus.sw_adr   = 3'd6;
        bus.auto_inc = 1'b1;
      end
    end
    total++;
    if (pulses != 1) begin
      bad++;
      $display("FAIL hold_count got=%0d exp=1", pulses);
    end
    total++;
    if (bus.W_Adr !== 3'd2 || bus.Din !== 4'h3 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL hold_stable got adr=%0d din=%h busy=%b exp adr=2 din=3 busy=1",
               bus.W_Adr, bus.Din, bus.busy);
    end
    bus.btn_raw = 1'b0;
    repeat (8) tick();
    total++;
    if (bus.busy !== 1'b0 || bus.Din !== 4'h3) begin
      bad++;
      $display("FAIL hold_release got busy=%b din=%h exp busy=0 din=3", bus.busy, bus.Din);
    end
  endtask

  task automatic test_reset_in_pulse();
    int pulses;
    pulses = 0;
    bus.auto_inc = 1'b1;
    bus.sw_din   = 4'h5;
    bus.btn_raw  = 1'b1;
    repeat (7) tick();
    // adr_cnt is 1 here: nine auto presses wrapped once, the long hold was manual.
    total++;
    if (bus.we_pulse !== 1'b1 || bus.W_Adr !== 3'd1) begin
      bad++;
      $display("FAIL rst_pre got we=%b adr=%0d exp we=1 adr=1", bus.we_pulse, bus.W_Adr);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (bus.we_pulse !== 1'b0 || bus.busy !== 1'b0 || bus.W_Adr !== 3'd0 || bus.Din !== 4'h0)
    begin
      bad++;
      $display("FAIL rst_pulse got we=%b busy=%b adr=%0d din=%h exp 0 0 0 0",
               bus.we_pulse, bus.busy, bus.W_Adr, bus.Din);
    end
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (bus.we_pulse === 1'b1) pulses++;
      total++;
      if (bus.we_pulse !== (e == 7)) begin
        bad++;
        $display("FAIL rst_repress_we edge=%0d got=%b exp=%b", e, bus.we_pulse, (e == 7));
      end
      if (e == 7) begin
        total++;
        if (bus.W_Adr !== 3'd0 || bus.Din !== 4'h5) begin
          bad++;
          $display("FAIL rst_repress_capture got adr=%0d din=%h exp adr=0 din=5",
                   bus.W_Adr, bus.Din);
        end
      end
    end
    total++;
    if (pulses != 1) begin
      bad++;
      $display("FAIL rst_repress_count got=%0d exp=1", pulses);
    end
    bus.btn_raw = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    reset        = 1'b1;
    bus.btn_raw  = 1'b0;
    bus.sw_adr   = 3'd0;
    bus.sw_din   = 4'h0;
    bus.auto_inc = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    test_reset();
    test_manual();
    test_glitch();
    test_auto_inc();
    test_long_hold();
    test_reset_in_pulse();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
